// File: rtl/piso_tx.sv
// MSB-first parallel-in/serial-out transmitter; first bit one cycle after acceptance.
// Backpressure: load_ready drops while a frame shifts and reopens on its last bit.
module piso_tx #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             sout_nxt, sout_valid_nxt, done_nxt;
  logic             accept;

  assign load_ready = (state == IDLE) || (cnt == LAST);
  assign accept     = load_valid && load_ready;

  // shreg holds the bits not yet on sout, next one at the MSB.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    shreg_nxt      = shreg;
    sout_nxt       = 1'b0;
    sout_valid_nxt = 1'b0;
    done_nxt       = 1'b0;
    if (accept) begin
      state_nxt      = SHIFT;
      cnt_nxt        = '0;
      shreg_nxt      = {load_data[WIDTH-2:0], 1'b0};
      sout_nxt       = load_data[WIDTH-1];
      sout_valid_nxt = 1'b1;
    end else if (state == SHIFT && cnt != LAST) begin
      cnt_nxt        = cnt + CW'(1);
      shreg_nxt      = {shreg[WIDTH-2:0], 1'b0};
      sout_nxt       = shreg[WIDTH-1];
      sout_valid_nxt = 1'b1;
      done_nxt       = (cnt == PENULT);
    end else if (state == SHIFT) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      shreg_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shreg      <= shreg_nxt;
      sout       <= sout_nxt;
      sout_valid <= sout_valid_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: directed frames plus random traffic against a position-based model
// and a loopback receiver.
module tb_piso_tx;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_data;
  logic         sout;
  logic         sout_valid;
  logic         done;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .sout       (sout),
    .sout_valid (sout_valid),
    .done       (done)
  );

  int checks   = 0;
  int failures = 0;

  // model: the word on the wire and which of its bit positions is shown now
  bit           m_act;
  int           m_pos;
  logic [W-1:0] m_word;
  logic [W-1:0] rx;
  int           n_valid, n_done, n_acc;
  bit           last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return !m_act || m_pos == 0;
  endfunction

  task automatic cycle(input bit v, input logic [W-1:0] d);
    bit acc;
    load_valid = v;
    load_data  = d;
    #1;
    check("load_ready", 32'(load_ready), 32'(m_ready()));
    acc = v && m_ready();
    last_acc = acc;
    @(posedge clk);
    if (acc) begin
      m_act  = 1'b1;
      m_word = d;
      m_pos  = W - 1;
      n_acc++;
    end else if (m_act && m_pos > 0) begin
      m_pos--;
    end else begin
      m_act = 1'b0;
      m_pos = 0;
    end
    #1;
    check("sout",       32'(sout),       32'(m_act ? m_word[m_pos] : 1'b0));
    check("sout_valid", 32'(sout_valid), 32'(m_act));
    check("done",       32'(done),       32'(m_act && m_pos == 0));
    if (sout_valid) begin
      rx = {rx[W-2:0], sout};
      n_valid++;
    end
    if (done) begin
      n_done++;
      check("loopback", 32'(rx), 32'(m_word));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, W'($urandom));
  endtask

  task automatic clear_counts();
    n_valid = 0;
    n_done  = 0;
    n_acc   = 0;
  endtask

  initial begin
    bit           hold;
    logic [W-1:0] hd;
    bit           v;
    logic [W-1:0] d;
    int           guard;

    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    m_act      = 1'b0;
    m_pos      = 0;
    m_word     = '0;
    rx         = '0;
    last_acc   = 1'b0;
    clear_counts();
    #2;
    check("rst_sout",       32'(sout),       32'd0);
    check("rst_sout_valid", 32'(sout_valid), 32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // single word, acceptance on the first edge after reset release
    clear_counts();
    cycle(1'b1, 16'hA5C3);
    idle(17);
    check("a5c3_word",   32'(rx), 32'h0000_A5C3);
    check("a5c3_valids", 32'(n_valid), 32'd16);
    check("a5c3_dones",  32'(n_done),  32'd1);

    // back-to-back frames with no gap
    clear_counts();
    cycle(1'b1, 16'hFFFF);
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'h0001);
    idle(17);
    check("b2b_word",   32'(rx), 32'h0000_0001);
    check("b2b_valids", 32'(n_valid), 32'd32);
    check("b2b_dones",  32'(n_done),  32'd2);

    // held load_valid during a frame is accepted only on its last bit
    clear_counts();
    cycle(1'b1, 16'h5A3C);
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'h1234);
    idle(17);
    check("bp_word",   32'(rx), 32'h0000_1234);
    check("bp_accept", 32'(n_acc), 32'd2);
    check("bp_valids", 32'(n_valid), 32'd32);

    // reset mid-frame after 5 bits
    clear_counts();
    cycle(1'b1, 16'hF0F0);
    idle(4);
    check("mid_bits_sent", 32'(n_valid), 32'd5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sout",       32'(sout),       32'd0);
    check("mid_rst_sout_valid", 32'(sout_valid), 32'd0);
    check("mid_rst_done",       32'(done),       32'd0);
    check("mid_rst_load_ready", 32'(load_ready), 32'd1);
    m_act = 1'b0;
    m_pos = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_counts();
    idle(20);
    check("post_rst_valids", 32'(n_valid), 32'd0);

    // random traffic with sources that hold until accepted
    clear_counts();
    hold  = 1'b0;
    hd    = '0;
    guard = 0;
    while (n_acc < 100 && guard < 20000) begin
      if (hold) begin
        v = 1'b1;
        d = hd;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        d = W'($urandom);
      end
      cycle(v, d);
      hold = v && !last_acc;
      hd   = d;
      guard++;
    end
    idle(18);
    check("rand_words",  32'(n_acc >= 100), 32'd1);
    check("rand_dones",  32'(n_done),  32'(n_acc));
    check("rand_valids", 32'(n_valid), 32'(n_acc * W));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
